// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the frame-RAM read arbiter.
// The response stage carries the forwarding fields even when forwarding is compiled out.
package mem_arb_pkg;

    localparam int RD_LATENCY     = 2;
    localparam int DEF_DAT_WIDTH  = 36;
    localparam int DEF_ADDR_WIDTH = 7;

    typedef logic req_id_t;

    // fwd_data is sized for the default RAM word width
    typedef struct packed {
        logic                     valid;
        req_id_t                  id;
        logic                     fwd;
        logic [DEF_DAT_WIDTH-1:0] fwd_data;
    } rsp_stage_t;

endpackage

// File: rtl/mem_rd_arbiter_if.sv
// Bundle of requester, write and RAM-port signals around the frame-RAM read arbiter.
// slave is the arbiter's view; master is the surrounding system (requesters + RAM).
interface mem_rd_arbiter_if #(
    parameter int DAT_WIDTH  = 36,
    parameter int ADDR_WIDTH = 7
);
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DAT_WIDTH-1:0]  wr_data;

    logic                  r0_valid;
    logic [ADDR_WIDTH-1:0] r0_addr;
    logic                  r0_ready;
    logic                  r0_rvalid;
    logic                  r1_valid;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic                  r1_ready;
    logic                  r1_rvalid;
    logic [DAT_WIDTH-1:0]  rdata;

    logic                  mem_wren;
    logic [ADDR_WIDTH-1:0] mem_wraddress;
    logic [DAT_WIDTH-1:0]  mem_data;
    logic [ADDR_WIDTH-1:0] mem_rdaddress;
    logic [DAT_WIDTH-1:0]  mem_q;

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  r0_valid, r0_addr, r1_valid, r1_addr, mem_q,
        output r0_ready, r0_rvalid, r1_ready, r1_rvalid, rdata,
        output mem_wren, mem_wraddress, mem_data, mem_rdaddress
    );

    modport master (
        output wr_valid, wr_addr, wr_data,
        output r0_valid, r0_addr, r1_valid, r1_addr, mem_q,
        input  r0_ready, r0_rvalid, r1_ready, r1_rvalid, rdata,
        input  mem_wren, mem_wraddress, mem_data, mem_rdaddress
    );
endinterface

// File: rtl/mem_rd_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: at most one grant per cycle, and on a tie the
// requester not granted most recently wins. The pointer moves only on a grant.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig,
    output logic [1:0] gnt
);

    // requester favoured on a tie; reset favours requester 0
    req_id_t prio;

    always_comb begin
        gnt = 2'b00;
        if (elig[0] && (!elig[1] || prio == 1'b0)) begin
            gnt = 2'b01;
        end else if (elig[1]) begin
            gnt = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (gnt[0]) begin
            prio <= 1'b1;
        end else if (gnt[1]) begin
            prio <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Shares the frame-RAM read port between the LED refresh engine (r0) and host readback (r1),
// steers responses back after the RAM latency and blocks same-address read/write collisions.
// Optional macro RD_FWD_EN: forward colliding write data instead of stalling the read.
module mem_rd_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DAT_WIDTH  = DEF_DAT_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_rd_arbiter_if.slave  bus
);

    logic [1:0]            hazard;
    logic [1:0]            elig;
    logic [1:0]            gnt;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [DAT_WIDTH-1:0]  fwd_word;
    rsp_stage_t            stage_in;
    rsp_stage_t            pipe [RD_LATENCY];
    rsp_stage_t            rsp;

    assign bus.mem_wren      = bus.wr_valid;
    assign bus.mem_wraddress = bus.wr_addr;
    assign bus.mem_data      = bus.wr_data;

    assign hazard[0] = bus.wr_valid && (bus.wr_addr == bus.r0_addr);
    assign hazard[1] = bus.wr_valid && (bus.wr_addr == bus.r1_addr);

    // No grants may leak out while the block is held in reset.
`ifdef RD_FWD_EN
    assign elig = {bus.r1_valid, bus.r0_valid} & {2{rst_n}};
`else
    assign elig = {bus.r1_valid, bus.r0_valid} & ~hazard & {2{rst_n}};
`endif

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .elig  (elig),
        .gnt   (gnt)
    );

    assign bus.r0_ready = gnt[0];
    assign bus.r1_ready = gnt[1];

    assign gnt_addr          = gnt[1] ? bus.r1_addr : bus.r0_addr;
    assign bus.mem_rdaddress = (|gnt) ? gnt_addr : last_addr;

    always_comb begin
        stage_in       = '0;
        stage_in.valid = |gnt;
        stage_in.id    = gnt[1];
`ifdef RD_FWD_EN
        stage_in.fwd      = gnt[1] ? hazard[1] : (gnt[0] && hazard[0]);
        stage_in.fwd_data = bus.wr_data;
`endif
    end

    // Holding the last granted address keeps the RAM address input quiet between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe[i] <= '0;
            end
            last_addr <= '0;
        end else begin
            pipe[0] <= stage_in;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
            if (|gnt) begin
                last_addr <= gnt_addr;
            end
        end
    end

    assign rsp           = pipe[RD_LATENCY-1];
    assign fwd_word      = rsp.fwd_data;
    assign bus.r0_rvalid = rsp.valid && (rsp.id == 1'b0);
    assign bus.r1_rvalid = rsp.valid && (rsp.id == 1'b1);
    assign bus.rdata     = rsp.fwd ? fwd_word : bus.mem_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter with a registered-address/registered-output RAM model.
// Honours RD_FWD_EN so the same bench covers both builds.
module tb_mem_rd_arbiter;

    localparam int DW = 36;
    localparam int AW = 7;
    localparam logic [DW-1:0] POISON = 36'hBAD_BAD_BAD;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    mem_rd_arbiter_if #(.DAT_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_rd_arbiter #(.DAT_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [2**AW];
    logic [DW-1:0] ram_stage;

    function automatic logic [DW-1:0] init_word(input int a);
        return 36'h5_0000_0000 | DW'(a * 'h111);
    endfunction

    // A same-cycle read/write collision returns a poison word.
    always @(posedge clk) begin
        if (bus.mem_wren) ram[bus.mem_wraddress] <= bus.mem_data;
        ram_stage <= (bus.mem_wren && bus.mem_wraddress == bus.mem_rdaddress) ? POISON : ram[bus.mem_rdaddress];
        bus.mem_q <= ram_stage;
    end

    task automatic idle_inputs;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.r0_valid = 1'b0;
        bus.r0_addr  = '0;
        bus.r1_valid = 1'b0;
        bus.r1_addr  = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        bus.r0_valid = 1'b1;
        bus.r0_addr  = 7'h05;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 7'h7F;
        bus.wr_data  = 36'h123;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_checks++; if (bus.r0_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_r0_ready: got %b expected 0", bus.r0_ready); end
            n_checks++; if (bus.r1_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_r1_ready: got %b expected 0", bus.r1_ready); end
            n_checks++; if (bus.r0_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_r0_rvalid: got %b expected 0", bus.r0_rvalid); end
            n_checks++; if (bus.r1_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_r1_rvalid: got %b expected 0", bus.r1_rvalid); end
            n_checks++; if (bus.mem_rdaddress !== 7'h00) begin n_fail++; $display("[TB] FAIL reset_rdaddress: got %h expected 00", bus.mem_rdaddress); end
        end
        n_checks++; if (bus.mem_wren !== 1'b1) begin n_fail++; $display("[TB] FAIL wr_pass_wren: got %b expected 1", bus.mem_wren); end
        n_checks++; if (bus.mem_wraddress !== 7'h7F) begin n_fail++; $display("[TB] FAIL wr_pass_addr: got %h expected 7f", bus.mem_wraddress); end
        n_checks++; if (bus.mem_data !== 36'h123) begin n_fail++; $display("[TB] FAIL wr_pass_data: got %h expected 123", bus.mem_data); end

        @(negedge clk);
        rst_n = 1'b1;
        bus.wr_valid = 1'b0;
        #1;
        n_checks++; if (bus.r0_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL first_grant_r0: got %b expected 1", bus.r0_ready); end
        n_checks++; if (bus.r1_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL first_grant_r1: got %b expected 0", bus.r1_ready); end
        n_checks++; if (bus.mem_rdaddress !== 7'h05) begin n_fail++; $display("[TB] FAIL first_grant_addr: got %h expected 05", bus.mem_rdaddress); end

        @(negedge clk);
        bus.r0_valid = 1'b0;
        #1;
        n_checks++; if (bus.r0_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL first_rvalid_early: got %b expected 0", bus.r0_rvalid); end
        @(negedge clk); #1;
        n_checks++; if (bus.r0_rvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL first_rvalid: got %b expected 1", bus.r0_rvalid); end
        n_checks++; if (bus.r1_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL first_r1_rvalid: got %b expected 0", bus.r1_rvalid); end
        n_checks++; if (bus.rdata !== init_word(5)) begin n_fail++; $display("[TB] FAIL first_rdata: got %h expected %h", bus.rdata, init_word(5)); end
        @(negedge clk); #1;
        n_checks++; if (bus.r0_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL first_rvalid_single: got %b expected 0", bus.r0_rvalid); end
        n_checks++; if (bus.mem_rdaddress !== 7'h05) begin n_fail++; $display("[TB] FAIL rdaddress_hold: got %h expected 05", bus.mem_rdaddress); end
    endtask

    task automatic test_round_robin;
        logic          exp0, exp1, eid;
        logic [AW-1:0] exp_addr;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            rst_n = 1'b1;
            bus.r0_valid = (k < 6);
            bus.r1_valid = (k < 6);
            bus.r0_addr  = 7'h10;
            bus.r1_addr  = 7'h20;
            #1;
            exp0 = (k < 6) && (k % 2 == 0);
            exp1 = (k < 6) && (k % 2 == 1);
            n_checks++; if (bus.r0_ready !== exp0) begin n_fail++; $display("[TB] FAIL rr_r0_ready k=%0d: got %b expected %b", k, bus.r0_ready, exp0); end
            n_checks++; if (bus.r1_ready !== exp1) begin n_fail++; $display("[TB] FAIL rr_r1_ready k=%0d: got %b expected %b", k, bus.r1_ready, exp1); end
            if (k < 6) begin
                exp_addr = (k % 2 == 1) ? 7'h20 : 7'h10;
                n_checks++; if (bus.mem_rdaddress !== exp_addr) begin n_fail++; $display("[TB] FAIL rr_rdaddress k=%0d: got %h expected %h", k, bus.mem_rdaddress, exp_addr); end
            end
            if (k >= 2 && k < 8) begin
                eid = ((k - 2) % 2 == 1);
                n_checks++; if (bus.r0_rvalid !== !eid) begin n_fail++; $display("[TB] FAIL rr_r0_rvalid k=%0d: got %b expected %b", k, bus.r0_rvalid, !eid); end
                n_checks++; if (bus.r1_rvalid !== eid) begin n_fail++; $display("[TB] FAIL rr_r1_rvalid k=%0d: got %b expected %b", k, bus.r1_rvalid, eid); end
                n_checks++; if (bus.rdata !== init_word(eid ? 'h20 : 'h10)) begin n_fail++; $display("[TB] FAIL rr_rdata k=%0d: got %h expected %h", k, bus.rdata, init_word(eid ? 'h20 : 'h10)); end
            end else begin
                n_checks++; if ((bus.r0_rvalid | bus.r1_rvalid) !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_rvalid_idle k=%0d: got %b%b expected 00", k, bus.r1_rvalid, bus.r0_rvalid); end
            end
        end
    endtask

    task automatic test_hazard;
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 7'h1A;
        bus.wr_data  = 36'hABC;
        bus.r1_valid = 1'b1;
        bus.r1_addr  = 7'h1A;
        #1;
        n_checks++; if (bus.mem_wren !== 1'b1) begin n_fail++; $display("[TB] FAIL hz_wren: got %b expected 1", bus.mem_wren); end
`ifdef RD_FWD_EN
        n_checks++; if (bus.r1_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL hz_fwd_ready: got %b expected 1", bus.r1_ready); end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.r1_valid = 1'b0;
        #1;
        n_checks++; if (bus.r1_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL hz_rvalid_early: got %b expected 0", bus.r1_rvalid); end
`else
        n_checks++; if (bus.r1_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL hz_stall: got %b expected 0", bus.r1_ready); end
        n_checks++; if (bus.r0_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL hz_r0_ready: got %b expected 0", bus.r0_ready); end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        #1;
        n_checks++; if (bus.r1_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL hz_retry_ready: got %b expected 1", bus.r1_ready); end
        @(negedge clk);
        bus.r1_valid = 1'b0;
        #1;
        n_checks++; if (bus.r1_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL hz_rvalid_early: got %b expected 0", bus.r1_rvalid); end
`endif
        @(negedge clk); #1;
        n_checks++; if (bus.r1_rvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL hz_rvalid: got %b expected 1", bus.r1_rvalid); end
        n_checks++; if (bus.r0_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL hz_r0_rvalid: got %b expected 0", bus.r0_rvalid); end
        n_checks++; if (bus.rdata !== 36'hABC) begin n_fail++; $display("[TB] FAIL hz_rdata: got %h expected abc", bus.rdata); end
        @(negedge clk);
    endtask

    task automatic test_hazard_bypass;
        logic first_r0;
`ifdef RD_FWD_EN
        first_r0 = 1'b1;
`else
        first_r0 = 1'b0;
`endif
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 7'h03;
        bus.wr_data  = 36'h333;
        bus.r0_valid = 1'b1;
        bus.r0_addr  = 7'h03;
        bus.r1_valid = 1'b1;
        bus.r1_addr  = 7'h04;
        #1;
        n_checks++; if (bus.r0_ready !== first_r0) begin n_fail++; $display("[TB] FAIL byp_r0_ready: got %b expected %b", bus.r0_ready, first_r0); end
        n_checks++; if (bus.r1_ready !== !first_r0) begin n_fail++; $display("[TB] FAIL byp_r1_ready: got %b expected %b", bus.r1_ready, !first_r0); end
        n_checks++; if (bus.mem_rdaddress !== (first_r0 ? 7'h03 : 7'h04)) begin n_fail++; $display("[TB] FAIL byp_rdaddress: got %h expected %h", bus.mem_rdaddress, first_r0 ? 7'h03 : 7'h04); end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        if (first_r0) bus.r0_valid = 1'b0;
        else bus.r1_valid = 1'b0;
        #1;
        n_checks++; if (bus.r0_ready !== !first_r0) begin n_fail++; $display("[TB] FAIL byp_second_r0: got %b expected %b", bus.r0_ready, !first_r0); end
        n_checks++; if (bus.r1_ready !== first_r0) begin n_fail++; $display("[TB] FAIL byp_second_r1: got %b expected %b", bus.r1_ready, first_r0); end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (bus.r0_rvalid !== first_r0) begin n_fail++; $display("[TB] FAIL byp_rsp1_r0: got %b expected %b", bus.r0_rvalid, first_r0); end
        n_checks++; if (bus.r1_rvalid !== !first_r0) begin n_fail++; $display("[TB] FAIL byp_rsp1_r1: got %b expected %b", bus.r1_rvalid, !first_r0); end
        n_checks++; if (bus.rdata !== (first_r0 ? 36'h333 : init_word(4))) begin n_fail++; $display("[TB] FAIL byp_rsp1_data: got %h expected %h", bus.rdata, first_r0 ? 36'h333 : init_word(4)); end
        @(negedge clk); #1;
        n_checks++; if (bus.r0_rvalid !== !first_r0) begin n_fail++; $display("[TB] FAIL byp_rsp2_r0: got %b expected %b", bus.r0_rvalid, !first_r0); end
        n_checks++; if (bus.r1_rvalid !== first_r0) begin n_fail++; $display("[TB] FAIL byp_rsp2_r1: got %b expected %b", bus.r1_rvalid, first_r0); end
        n_checks++; if (bus.rdata !== (first_r0 ? init_word(4) : 36'h333)) begin n_fail++; $display("[TB] FAIL byp_rsp2_data: got %h expected %h", bus.rdata, first_r0 ? init_word(4) : 36'h333); end
    endtask

    task automatic test_reset_midflight;
        @(negedge clk);
        bus.r0_valid = 1'b1;
        bus.r0_addr  = 7'h08;
        #1;
        n_checks++; if (bus.r0_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_grant: got %b expected 1", bus.r0_ready); end
        @(negedge clk);
        bus.r0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.mem_rdaddress !== 7'h00) begin n_fail++; $display("[TB] FAIL mid_rdaddress: got %h expected 00", bus.mem_rdaddress); end
        n_checks++; if ((bus.r0_rvalid | bus.r1_rvalid) !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rvalid_in_reset: got %b%b expected 00", bus.r1_rvalid, bus.r0_rvalid); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus.r0_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_discard: got %b expected 0", bus.r0_rvalid); end
        n_checks++; if (bus.r1_rvalid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_discard_r1: got %b expected 0", bus.r1_rvalid); end
        @(negedge clk);
        bus.r0_valid = 1'b1;
        bus.r0_addr  = 7'h10;
        bus.r1_valid = 1'b1;
        bus.r1_addr  = 7'h20;
        #1;
        n_checks++; if (bus.r0_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_prio_r0: got %b expected 1", bus.r0_ready); end
        n_checks++; if (bus.r1_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_prio_r1: got %b expected 0", bus.r1_ready); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk); #1;
        n_checks++; if (bus.r0_rvalid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_after_rvalid: got %b expected 1", bus.r0_rvalid); end
        n_checks++; if (bus.rdata !== init_word('h10)) begin n_fail++; $display("[TB] FAIL mid_after_rdata: got %h expected %h", bus.rdata, init_word('h10)); end
        @(negedge clk); #1;
        n_checks++; if ((bus.r0_rvalid | bus.r1_rvalid) !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_drain: got %b%b expected 00", bus.r1_rvalid, bus.r0_rvalid); end
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) ram[i] = init_word(i);
        ram_stage = '0;
        bus.mem_q = '0;
        test_reset();
        test_round_robin();
        test_hazard();
        test_hazard_bypass();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
